// File: rtl/fp_add_pkg.sv
// Shared types and constants for the multi-cycle floating-point add/accumulate block.
// Default widths give IEEE-754 single precision.
package fp_add_pkg;

  localparam int EXP_W_DEF = 8;
  localparam int MAN_W_DEF = 23;
  localparam int W_DEF     = 1 + EXP_W_DEF + MAN_W_DEF;

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND, DONE} state_t;

  localparam logic [W_DEF-1:0] QNAN_DEF = 32'h7FC0_0000;
  localparam logic [W_DEF-1:0] INF_DEF  = 32'h7F80_0000;

  function automatic logic f_sign(input logic [W_DEF-1:0] w);
    return w[W_DEF-1];
  endfunction

  function automatic logic [EXP_W_DEF-1:0] f_exp(input logic [W_DEF-1:0] w);
    return w[W_DEF-2:MAN_W_DEF];
  endfunction

  function automatic logic [MAN_W_DEF-1:0] f_man(input logic [W_DEF-1:0] w);
    return w[MAN_W_DEF-1:0];
  endfunction

endpackage

// File: rtl/fp_add_acc_if.sv
// Operand/result handshake bundle between a requester and fp_add_acc.
interface fp_add_acc_if #(
  parameter int W = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         sub;
  logic         acc;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;

  modport master (
    output in_valid, op_a, op_b, sub, acc, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  in_valid, op_a, op_b, sub, acc, out_ready,
    output in_ready, out_valid, result
  );
endinterface

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; an all-zero input reports W.
module fp_lzc #(
  parameter int W = 27
) (
  input  logic [W-1:0]             value,
  output logic [$clog2(W+1)-1:0]   count
);
  logic found;

  always_comb begin
    count = '0;
    found = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (!found) begin
        if (value[i]) found = 1'b1;
        else          count = count + 1'b1;
      end
    end
  end
endmodule

// File: rtl/fp_add_acc.sv
// Multi-cycle FP adder/subtractor (ALIGN/ADD/NORM/ROUND) with flush-to-zero,
// round-to-nearest-even, and a result register reusable as operand A.
module fp_add_acc
  import fp_add_pkg::*;
#(
  parameter int EXP_W = EXP_W_DEF,
  parameter int MAN_W = MAN_W_DEF
) (
  input logic        clock,
  input logic        reset,
  fp_add_acc_if.slave bus
);
  localparam int W   = 1 + EXP_W + MAN_W;
  localparam int MW  = MAN_W + 4;           // hidden, fraction, guard, round, sticky
  localparam int XW  = EXP_W + 2;           // signed exponent with headroom
  localparam int LZW = $clog2(MW + 1);
  localparam logic [EXP_W-1:0]     EMAX = '1;
  localparam logic [W-1:0]         QNAN = {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic signed [XW-1:0] XMAX = $signed({2'b00, EMAX});
  localparam logic [MW-1:0]        ONES = '1;

  state_t state, nxt;

  logic [W-1:0]          a_q, b_q, res_q, spec_val_q;
  logic                  sgn_q, eff_sub_q, spec_q, zero_q;
  logic [EXP_W-1:0]      exp_q;
  logic [MW-1:0]         ml_q, ms_q, mn_q;
  logic [MW:0]           sum_q;
  logic signed [XW-1:0]  xn_q;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt           = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state)
      IDLE:    begin bus.in_ready = 1'b1; if (bus.in_valid) nxt = ALIGN; end
      ALIGN:   nxt = ADD;
      ADD:     nxt = NORM;
      NORM:    nxt = ROUND;
      ROUND:   nxt = DONE;
      DONE:    begin bus.out_valid = 1'b1; if (bus.out_ready) nxt = IDLE; end
      default: nxt = IDLE;
    endcase
  end

  assign bus.result = res_q;

  // ALIGN: classify, order by magnitude, shift the smaller significand
  logic [EXP_W-1:0] ea, eb, el, es, d;
  logic             a_nan, b_nan, a_inf, b_inf, a_big, sgn_l, spec;
  logic [W-2:0]     mag_a, mag_b, mag_l, mag_s;
  logic [MW-1:0]    m_l, m_s, m_sh;
  logic [W-1:0]     spec_val;

  always_comb begin
    ea    = a_q[W-2:MAN_W];
    eb    = b_q[W-2:MAN_W];
    a_nan = (ea == EMAX) && (a_q[MAN_W-1:0] != '0);
    b_nan = (eb == EMAX) && (b_q[MAN_W-1:0] != '0);
    a_inf = (ea == EMAX) && (a_q[MAN_W-1:0] == '0);
    b_inf = (eb == EMAX) && (b_q[MAN_W-1:0] == '0);
    mag_a = (ea == '0) ? '0 : a_q[W-2:0];
    mag_b = (eb == '0) ? '0 : b_q[W-2:0];
    a_big = mag_a >= mag_b;
    mag_l = a_big ? mag_a : mag_b;
    mag_s = a_big ? mag_b : mag_a;
    sgn_l = a_big ? a_q[W-1] : b_q[W-1];
    el    = mag_l[W-2:MAN_W];
    es    = mag_s[W-2:MAN_W];
    d     = el - es;
    m_l   = {el != '0, mag_l[MAN_W-1:0], 3'b000};
    m_s   = {es != '0, mag_s[MAN_W-1:0], 3'b000};
    if (int'(d) >= MW) m_sh = {{(MW-1){1'b0}}, |m_s};
    else               m_sh = (m_s >> d) | {{(MW-1){1'b0}}, |(m_s & ~(ONES << d))};
    spec     = 1'b1;
    spec_val = QNAN;
    if (a_nan || b_nan || (a_inf && b_inf && (a_q[W-1] != b_q[W-1]))) spec_val = QNAN;
    else if (a_inf) spec_val = {a_q[W-1], EMAX, {MAN_W{1'b0}}};
    else if (b_inf) spec_val = {b_q[W-1], EMAX, {MAN_W{1'b0}}};
    else            spec     = 1'b0;
  end

  logic [MW:0] sum;
  assign sum = eff_sub_q ? ({1'b0, ml_q} - {1'b0, ms_q}) : ({1'b0, ml_q} + {1'b0, ms_q});

  // NORM: carry folds the dropped bit into sticky; otherwise one-shot left shift
  logic [LZW-1:0]       lz;
  logic [MW-1:0]        mn;
  logic signed [XW-1:0] xn;

  fp_lzc #(.W(MW)) u_lzc (.value(sum_q[MW-1:0]), .count(lz));

  always_comb begin
    if (sum_q[MW]) begin
      mn = {sum_q[MW:2], sum_q[1] | sum_q[0]};
      xn = $signed({2'b00, exp_q}) + 1;
    end else begin
      mn = sum_q[MW-1:0] << lz;
      xn = $signed({2'b00, exp_q}) - $signed({{(XW-LZW){1'b0}}, lz});
    end
  end

  logic [MAN_W+1:0]     mr;
  logic                 up, ovf;
  logic signed [XW-1:0] xr;
  logic [W-1:0]         rnd;

  always_comb begin
    up  = mn_q[2] & (mn_q[3] | mn_q[1] | mn_q[0]);
    mr  = {1'b0, mn_q[MW-1:3]} + {{(MAN_W+1){1'b0}}, up};
    ovf = mr[MAN_W+1];
    xr  = xn_q + $signed({{(XW-1){1'b0}}, ovf});
    if (spec_q)         rnd = spec_val_q;
    else if (zero_q)    rnd = {sgn_q & ~eff_sub_q, {(W-1){1'b0}}};
    else if (xn_q <= 0) rnd = {sgn_q, {(W-1){1'b0}}};
    else if (xr >= XMAX) rnd = {sgn_q, EMAX, {MAN_W{1'b0}}};
    else                rnd = {sgn_q, xr[EXP_W-1:0], ovf ? mr[MAN_W:1] : mr[MAN_W-1:0]};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      a_q <= '0; b_q <= '0; res_q <= '0; spec_val_q <= '0;
      sgn_q <= 1'b0; eff_sub_q <= 1'b0; spec_q <= 1'b0; zero_q <= 1'b0;
      exp_q <= '0; ml_q <= '0; ms_q <= '0; mn_q <= '0; sum_q <= '0; xn_q <= '0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          a_q <= bus.acc ? res_q : bus.op_a;
          b_q <= {bus.op_b[W-1] ^ bus.sub, bus.op_b[W-2:0]};
        end
        ALIGN: begin
          sgn_q <= sgn_l; eff_sub_q <= a_q[W-1] ^ b_q[W-1]; exp_q <= el;
          ml_q <= m_l; ms_q <= m_sh; spec_q <= spec; spec_val_q <= spec_val;
        end
        ADD:   sum_q <= sum;
        NORM:  begin mn_q <= mn; xn_q <= xn; zero_q <= (sum_q == '0); end
        ROUND: res_q <= rnd;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_add_acc.sv
// Directed and randomized checks of fp_add_acc against an exact-arithmetic reference.
module tb_fp_add_acc;
  import fp_add_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fp_add_acc_if #(.W(32)) bus ();
  fp_add_acc dut (.clock(clk), .reset(rst), .bus(bus));

  int n_tot = 0;
  int n_bad = 0;
  logic [31:0] mdl_res;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Exact sum as a wide integer scaled by 2^-149, then RNE to 24 bits.
  function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
    logic [299:0] va, vb, mag, q, rem, half, one;
    logic sa, sb, s, up;
    int ea, eb, p, e, sh;
    sa = f_sign(a); sb = f_sign(b);
    ea = int'(f_exp(a)); eb = int'(f_exp(b));
    if ((ea == 255 && f_man(a) != 0) || (eb == 255 && f_man(b) != 0)) return QNAN_DEF;
    if (ea == 255 && eb == 255) return (sa == sb) ? a : QNAN_DEF;
    if (ea == 255) return a;
    if (eb == 255) return b;
    one = 1;
    va = (ea == 0) ? '0 : ({276'd0, 1'b1, f_man(a)} << (ea - 1));
    vb = (eb == 0) ? '0 : ({276'd0, 1'b1, f_man(b)} << (eb - 1));
    if (sa == sb)      begin mag = va + vb; s = sa; end
    else if (va >= vb) begin mag = va - vb; s = (va == vb) ? 1'b0 : sa; end
    else               begin mag = vb - va; s = sb; end
    if (mag == 0) return {s, 31'd0};
    p = 0;
    for (int i = 0; i < 300; i++) if (mag[i]) p = i;
    e = p - 22;
    if (e <= 0) return {s, 31'd0};
    sh   = p - 23;
    q    = mag >> sh;
    rem  = mag & ((one << sh) - one);
    half = (sh > 0) ? (one << (sh - 1)) : '0;
    up   = (sh > 0) && ((rem > half) || (rem == half && q[0]));
    q    = q + {299'd0, up};
    if (q[24]) begin q = q >> 1; e++; end
    if (e >= 255) return {s, INF_DEF[30:0]};
    return {s, e[7:0], q[22:0]};
  endfunction

  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic s, input logic ac, input logic [31:0] exp, input int hold);
    int lat;
    chk({tag, ".rdy"}, {31'd0, bus.in_ready}, 32'd1);
    bus.op_a = a; bus.op_b = b; bus.sub = s; bus.acc = ac; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.op_a = $urandom; bus.op_b = $urandom; bus.sub = 1'($urandom); bus.acc = 1'($urandom);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    chk({tag, ".lat"}, 32'(lat), 32'd4);
    chk(tag, bus.result, exp);
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      chk({tag, ".hold_res"}, bus.result, exp);
      chk({tag, ".hold_flags"}, {30'd0, bus.out_valid, bus.in_ready}, 32'd2);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk({tag, ".drop"}, {30'd0, bus.out_valid, bus.in_ready}, 32'd1);
    mdl_res = exp;
  endtask

  initial begin
    logic [31:0] a, b, exp;
    logic        s, ac;
    int          seen;
    bus.in_valid = 1'b0; bus.op_a = '0; bus.op_b = '0; bus.sub = 1'b0; bus.acc = 1'b0;
    bus.out_ready = 1'b0;
    mdl_res = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst.res", bus.result, 32'd0);
    chk("rst.flags", {30'd0, bus.out_valid, bus.in_ready}, 32'd1);

    do_op("one_plus_m2", 32'h3F800000, 32'hC0000000, 1'b0, 1'b0, 32'hBF800000, 0);
    do_op("tie_up",      32'h3F800001, 32'h33800000, 1'b0, 1'b0, 32'h3F800002, 0);
    do_op("tie_down",    32'h3F800000, 32'h33800000, 1'b0, 1'b0, 32'h3F800000, 0);
    do_op("acc1",        32'h00000000, 32'h3F800000, 1'b0, 1'b0, 32'h3F800000, 0);
    do_op("acc2",        32'h12345678, 32'h40000000, 1'b0, 1'b1, 32'h40400000, 0);
    do_op("acc3",        32'hDEADBEEF, 32'h40400000, 1'b0, 1'b1, 32'h40C00000, 0);
    do_op("cancel",      32'h3FC00000, 32'h3FC00000, 1'b1, 1'b0, 32'h00000000, 0);
    do_op("ovf_inf",     32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 1'b0, 32'h7F800000, 0);
    do_op("inf_m_inf",   32'h7F800000, 32'hFF800000, 1'b0, 1'b0, 32'h7FC00000, 10);
    do_op("inf_sub_inf", 32'h7F800000, 32'h7F800000, 1'b1, 1'b0, 32'h7FC00000, 0);
    do_op("ninf_fin",    32'hFF800000, 32'h3F800000, 1'b0, 1'b0, 32'hFF800000, 0);
    do_op("nan_in",      32'h7F800001, 32'h3F800000, 1'b0, 1'b0, 32'h7FC00000, 0);
    do_op("underflow",   32'h00800001, 32'h00800000, 1'b1, 1'b0, 32'h00000000, 0);
    do_op("subn_flush",  32'h00400000, 32'h3F800000, 1'b0, 1'b0, 32'h3F800000, 0);
    do_op("sub_big",     32'h40400000, 32'h3F800000, 1'b1, 1'b0, 32'h40000000, 0);

    // abort an operation while it sits in NORM
    bus.op_a = 32'h40000000; bus.op_b = 32'h40000000; bus.sub = 1'b0; bus.acc = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; bus.out_ready = 1'b0;
    chk("rst_mid.res", bus.result, 32'd0);
    chk("rst_mid.flags", {30'd0, bus.out_valid, bus.in_ready}, 32'd1);
    seen = 0;
    repeat (8) begin @(posedge clk); #1; if (bus.out_valid) seen++; end
    chk("rst_mid.no_vld", 32'(seen), 32'd0);
    mdl_res = '0;
    do_op("post_rst_acc", 32'hFFFFFFFF, 32'h3F800000, 1'b0, 1'b1, 32'h3F800000, 0);

    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 7))
        0: begin a = $urandom; b = $urandom; s = 1'($urandom); end
        1: begin
          a = {1'($urandom), 8'($urandom_range(100, 150)), 23'($urandom)};
          b = a ^ 32'($urandom_range(0, 15));
          s = 1'b1;
        end
        default: begin
          a = {1'($urandom), 8'($urandom_range(110, 145)), 23'($urandom)};
          b = {1'($urandom), 8'($urandom_range(110, 145)), 23'($urandom)};
          s = 1'($urandom);
        end
      endcase
      ac  = ($urandom_range(0, 3) == 0);
      exp = ref_add(ac ? mdl_res : a, {b[31] ^ s, b[30:0]});
      do_op("rnd", a, b, s, ac, exp, 0);
    end

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule

// File: doc/fp_add_acc.md
FP_ADD_ACC -- requirements
Module: fp_add_acc

Interface
REQ-001 Parameter EXP_W, default 8, exponent field width.
REQ-002 Parameter MAN_W, default 23, stored fraction width; word width W = 1+EXP_W+MAN_W (default 32, IEEE-754 single).
REQ-003 clock  input  1  sole clock, rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operand set present.
REQ-006 in_ready  output  1  block can accept operands.
REQ-007 op_a  input  W  first operand; ignored when acc=1.
REQ-008 op_b  input  W  second operand.
REQ-009 sub  input  1  1 computes A-B, 0 computes A+B.
REQ-010 acc  input  1  1 uses the previous result register as A.
REQ-011 out_valid  output  1  result valid.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 result  output  W  rounded sum.

Function
REQ-014 States: IDLE, ALIGN, ADD, NORM, ROUND, DONE; in_ready=1 only in IDLE.
REQ-015 Accept edge: IDLE and in_valid=1 -> latch A (op_a or result register), B (op_b with sign inverted if sub=1), go to ALIGN.
REQ-016 Transitions ALIGN->ADD->NORM->ROUND->DONE, unconditional, one cycle each; out_valid first high in the cycle after the 4th edge following accept.
REQ-017 ALIGN: swap so |A|>=|B|, right-shift B mantissa by exponent difference into guard/round/sticky; difference > MAN_W+3 leaves only sticky.
REQ-018 ADD: same signs add magnitudes, else subtract; result sign = sign of larger operand.
REQ-019 NORM: carry-out -> shift right 1, exponent+1; otherwise left-shift by leading-zero count in a single cycle, exponent reduced accordingly.
REQ-020 ROUND: round-to-nearest-even on guard/round/sticky; mantissa overflow from rounding increments exponent.
REQ-021 Exponent reaching all-ones after NORM/ROUND -> signed infinity.
REQ-022 Exponent underflow (<=0) -> signed zero; subnormal inputs are treated as zero (flush-to-zero).
REQ-023 Exact cancellation -> +0.
REQ-024 Any NaN input, or infinities of opposite effective sign -> canonical quiet NaN (sign 0, exponent all-ones, fraction MSB only).
REQ-025 Infinity plus finite -> that infinity.
REQ-026 DONE holds result and out_valid until out_ready=1; on that edge -> IDLE, out_valid=0.
REQ-027 result register retains its value after DONE for acc=1 use; accumulation chains are unlimited.
REQ-028 in_valid while not in IDLE is ignored; no operand is captured.

Reset
REQ-029 reset=1 at an edge -> state IDLE, out_valid=0, in_ready=1 from next cycle, result=0 (+0.0), all datapath registers 0.
REQ-030 reset mid-operation aborts the calculation; no out_valid is produced for it.
REQ-031 reset takes priority over in_valid and out_ready on the same edge.

Structure
REQ-032 Package fp_add_pkg holds the state enum typedef, default EXP_W/MAN_W, field-extract and canonical-NaN/infinity constants.
REQ-033 Single sub-module fp_lzc: parametrised combinational leading-zero counter used by NORM.

Verification
REQ-034 A=0x3F800000 (1.0), B=0xC0000000 (-2.0), sub=0 -> result 0xBF800000 (-1.0); out_valid after 4th edge following accept.
REQ-035 A=0x3F800001, B=0x33800000 (2^-24) -> 0x3F800002 (tie to even); A=0x3F800000, same B -> 0x3F800000.
REQ-036 Accumulate: 1.0 (acc=0, A=0x00000000 B=0x3F800000), then acc=1 with B=2.0, then B=3.0 -> final 0x40C00000 (6.0).
REQ-037 A=0x3FC00000, B=0x3FC00000, sub=1 -> 0x00000000; A=0x7F7FFFFF plus itself -> 0x7F800000.
REQ-038 A=0x7F800000, B=0xFF800000 -> 0x7FC00000; out_ready held low 10 cycles -> result and out_valid stable, in_ready=0 throughout.
REQ-039 reset asserted in NORM -> next cycle IDLE, out_valid never rises, result=0x00000000.
